// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-outstanding memory port among NUM_REQ requesters.
// Define MEM_ARB_TIMEOUT_EN to abort transactions whose memory never answers within TIMEOUT cycles.
module mem_port_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    req_err,
  output logic [DW-1:0]         req_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [AW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_wdata,
  input  logic                  mem_ready,
  input  logic [DW-1:0]         mem_rdata,
  output logic [1:0]            grant_id,
  output logic                  busy
);

  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT < 2) begin : g_bad_param
    $error("mem_port_arbiter: NUM_REQ must be 2..4 and TIMEOUT >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           last_q, last_d;
  logic [1:0]           grant_q, grant_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [AW-1:0]        mem_addr_q, mem_addr_d;
  logic [DW-1:0]        mem_wdata_q, mem_wdata_d;
  logic [NUM_REQ-1:0]   ready_q, ready_d;
  logic [DW-1:0]        rdata_q, rdata_d;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   err_q, err_d;
`endif

  // Requester fields widened to a fixed 4-entry view so a 2-bit index is always in range.
  logic [3:0]           valid4;
  logic [3:0]           we4;
  logic [AW-1:0]        addr_a  [4];
  logic [DW-1:0]        wdata_a [4];
  logic [3:0]           onehot4;
  logic [NUM_REQ-1:0]   grant_onehot;
  logic                 win_found;
  logic [1:0]           win_idx;

  assign valid4       = 4'(req_valid);
  assign we4          = 4'(req_we);
  assign onehot4      = 4'b0001 << grant_q;
  assign grant_onehot = onehot4[NUM_REQ-1:0];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      addr_a[i]  = '0;
      wdata_a[i] = '0;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_a[i]  = req_addr[i*AW +: AW];
      wdata_a[i] = req_wdata[i*DW +: DW];
    end
  end

  // Search last+1, last+2, ... modulo NUM_REQ; the first valid requester wins.
  always_comb begin
    logic [1:0] cand;
    win_found = 1'b0;
    win_idx   = last_q;
    cand      = last_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = 2'((32'(last_q) + 32'(k)) % NUM_REQ);
      if (!win_found && valid4[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ready_d     = ready_q;
    rdata_d     = rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d     = win_idx;
          last_d      = win_idx;
          mem_addr_d  = addr_a[win_idx];
          mem_wdata_d = wdata_a[win_idx];
          mem_we_d    = we4[win_idx];
          mem_req_d   = 1'b1;
          state_d     = S_BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end

      S_BUSY: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          ready_d   = grant_onehot;
          rdata_d   = mem_we_q ? '0 : mem_rdata;
          state_d   = S_GAP;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          ready_d   = grant_onehot;
          err_d     = grant_onehot;
          rdata_d   = '0;
          state_d   = S_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      // One dead cycle lets the requester see the pulse and drop valid before re-arbitration.
      S_GAP: begin
        ready_d = '0;
        rdata_d = '0;
        state_d = S_IDLE;
`ifdef MEM_ARB_TIMEOUT_EN
        err_d   = '0;
`endif
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q     <= S_IDLE;
      last_q      <= 2'(NUM_REQ - 1);
      grant_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ready_q     <= '0;
      rdata_q     <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign req_ready = ready_q;
  assign req_rdata = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q != S_IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
  assign req_err = err_q;
`else
  assign req_err = '0;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter that shares the single-outstanding 8-bit data-memory port (mem_req/mem_we/mem_addr/mem_wdata/mem_ready/mem_rdata) among NUM_REQ requesters, e.g. CPU data port plus a DMA/debug port.
- Each requester uses the same protocol the CPU core uses: hold valid and fields stable until a one-cycle ready pulse, then drop valid.
- Arbiter registers the granted request onto the memory bus and returns completion with read data or error.

Parameters:
- NUM_REQ, 2, number of requesters, legal 2..4.
- AW, 8, address width.
- DW, 8, data width.
- TIMEOUT, 16, max cycles mem_req stays high without mem_ready before abort, legal >= 2; used only with MEM_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NUM_REQ  per-requester request, held until its req_ready pulse.
- req_we  input  NUM_REQ  1 = write, 0 = read.
- req_addr  input  NUM_REQ*AW  flattened; requester i at [i*AW +: AW].
- req_wdata  input  NUM_REQ*DW  flattened write data.
- req_ready  output  NUM_REQ  one-cycle completion pulse, one-hot or zero.
- req_err  output  NUM_REQ  set with req_ready when the transaction timed out.
- req_rdata  output  DW  read data, valid while any req_ready bit is high.
- mem_req  output  1  memory request.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_ready  input  1  memory completion, sampled only in BUSY.
- mem_rdata  input  DW  memory read data, valid with mem_ready.
- grant_id  output  2  index of current or last granted requester.
- busy  output  1  high in BUSY and GAP.

Behaviour:
- Reset (synchronous, rst high at a rising edge):
  - state = IDLE; every output = 0.
  - RR pointer last = NUM_REQ-1, so requester 0 wins first; timeout counter = 0.
  - Reset mid-transaction drops mem_req on the next edge. Any memory response is discarded; no req_ready is issued.
- States: IDLE, BUSY, GAP.
- IDLE:
  - If any req_valid is high, pick the first high bit searching last+1, last+2, ... modulo NUM_REQ.
  - On that edge: set grant_id and last to the winner. Register mem_addr, mem_wdata and mem_we from the winner's fields. Set mem_req = 1, clear the counter, go to BUSY.
  - Latency: req_valid high before edge k -> mem_req high after edge k.
  - No valid: stay in IDLE, mem_req = 0.
- BUSY:
  - mem_req, mem_we, mem_addr, mem_wdata held constant.
  - Requester fields and req_valid are ignored; a valid drop mid-transaction does not abort.
  - mem_ready sampled high: mem_req <= 0, mem_we <= 0, req_ready[grant_id] <= 1, req_rdata <= mem_rdata (reads; 0 for writes), go to GAP.
  - A read completes on the same edge it is sampled; mem_rdata is registered.
- GAP (exactly one cycle):
  - req_ready/req_err pulse is visible; the requester samples it and drops valid at the next edge.
  - No arbitration in GAP, which prevents re-granting the still-high valid.
  - Next edge: clear req_ready, req_err, req_rdata; go to IDLE.
- mem_ready in IDLE or GAP is ignored and has no side effect.
- Fairness: with all requesters continuously active, grants rotate 0,1,...,NUM_REQ-1. Throughput is 1 transaction per (mem latency + 2) cycles, minimum 3 cycles.
- Widths: the RR modulo uses a 2-bit index; index values >= NUM_REQ are never produced.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - The counter increments each BUSY cycle with mem_ready low.
  - When the counter reaches TIMEOUT-1 with mem_ready still low: mem_req <= 0, req_ready[g] <= 1, req_err[g] <= 1, req_rdata <= 0, go to GAP.
  - mem_ready high on that same cycle wins: normal completion, err = 0.
- Not defined:
  - No counter; BUSY waits indefinitely.
  - req_err is tied to 0.

Test Plan:
- Req0 read, addr 0x10; memory asserts ready 3 cycles after mem_req with rdata 0xA5 -> mem_req high 1 cycle after valid, mem_addr 0x10, mem_we 0. req_ready[0] pulses once with req_rdata 0xA5 and req_err 0; mem_req low next cycle.
- Req1 write, addr 0x22, data 0x5C; ready returned on the first BUSY cycle -> mem_we 1, mem_wdata 0x5C. req_ready[1] pulses; total 3 cycles valid-to-IDLE.
- Req0 and req1 asserted the same cycle after reset and re-requesting continuously -> grant order 0,1,0,1. req_ready is never two bits at once.
- Req0 holds valid through the GAP cycle -> no second grant in GAP. mem_ready pulsed in IDLE -> no req_ready.
- MEM_ARB_TIMEOUT_EN, TIMEOUT=16, ready never asserted -> mem_req high exactly 16 cycles, then req_ready[0]=1, req_err[0]=1, req_rdata 0x00.
- rst asserted in BUSY -> all outputs 0 after that edge, no req_ready. After release with both valids high, requester 0 is granted first.
